// File: rtl/reset_sequencer.sv
// Central reset controller: synchronizes the board reset, then releases NUM_STAGES
// downstream resets in order, waiting for each stage's ack, with timeout and re-reset.
module reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HOLD    = 8,
    parameter int STAGE_DELAY = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sw_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] rst_n_out,
    output logic                  seq_done,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [2:0]            err_stage
);

    localparam int IDX_W  = $clog2(NUM_STAGES);
    localparam int HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam int DLY_W  = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
    localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(STAGE_DELAY - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_DELAY,
        S_WAIT_ACK,
        S_DONE,
        S_FAULT,
        S_SHUTDOWN
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [DLY_W-1:0]       dly_cnt_q, dly_cnt_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [NUM_STAGES-1:0]  rst_n_out_q, rst_n_out_d;
    logic                   timeout_err_q, timeout_err_d;
    logic [2:0]             err_stage_q, err_stage_d;

    logic [NUM_STAGES-1:0]  shut_mask;
    logic                   higher_seen;

    // Assert asynchronously, release only after SYNC_STAGES clean edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];

    // Shutdown drops the highest released stage: keep only bits with a set bit above them.
    always_comb begin
        shut_mask   = '0;
        higher_seen = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            shut_mask[i] = rst_n_out_q[i] & higher_seen;
            higher_seen  = higher_seen | rst_n_out_q[i];
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        hold_cnt_d    = hold_cnt_q;
        dly_cnt_d     = dly_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        rst_n_out_d   = rst_n_out_q;
        timeout_err_d = timeout_err_q;
        err_stage_d   = err_stage_q;

        case (state_q)
            S_HOLD: begin
                if (!rst_sync) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = S_DELAY;
                    idx_d     = '0;
                    dly_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            S_DELAY: begin
                if (dly_cnt_q == DLY_LAST) begin
                    rst_n_out_d[idx_q] = 1'b1;
                    wait_cnt_d         = '0;
                    state_d            = S_WAIT_ACK;
                end else begin
                    dly_cnt_d = dly_cnt_q + DLY_W'(1);
                end
            end
            S_WAIT_ACK: begin
                // An ack seen on the timeout edge still counts as success.
                if (stage_ack[idx_q]) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        dly_cnt_d = '0;
                        state_d   = S_DELAY;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_err_d = 1'b1;
                    err_stage_d   = 3'(idx_q);
                    state_d       = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_DONE: begin
                if (sw_rst_req) begin
                    state_d = S_SHUTDOWN;
                end
            end
            S_FAULT: begin
                if (sw_rst_req) begin
                    timeout_err_d = 1'b0;
                    err_stage_d   = '0;
                    state_d       = S_SHUTDOWN;
                end
            end
            S_SHUTDOWN: begin
                rst_n_out_d = shut_mask;
                if (shut_mask == '0) begin
                    hold_cnt_d = '0;
                    state_d    = S_HOLD;
                end
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_HOLD;
            idx_q         <= '0;
            hold_cnt_q    <= '0;
            dly_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            rst_n_out_q   <= '0;
            timeout_err_q <= 1'b0;
            err_stage_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            hold_cnt_q    <= hold_cnt_d;
            dly_cnt_q     <= dly_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            rst_n_out_q   <= rst_n_out_d;
            timeout_err_q <= timeout_err_d;
            err_stage_q   <= err_stage_d;
        end
    end

    assign rst_n_out   = rst_n_out_q;
    assign seq_done    = (state_q == S_DONE);
    assign busy        = (state_q == S_HOLD) || (state_q == S_DELAY) ||
                         (state_q == S_WAIT_ACK) || (state_q == S_SHUTDOWN);
    assign timeout_err = timeout_err_q;
    assign err_stage   = err_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench for reset_sequencer: a timeline model predicts every output
// after every edge from per-stage ack latencies and software re-reset points.
module tb_reset_sequencer;

    localparam int N     = 4;
    localparam int SS    = 2;
    localparam int MH    = 8;
    localparam int SD    = 16;
    localparam int AT    = 255;
    localparam int NEVER = AT + 100;
    localparam logic [31:0] RST_VEC = 32'h010;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         sw_rst_req;
    logic [N-1:0] stage_ack;
    logic [N-1:0] rst_n_out;
    logic         seq_done;
    logic         busy;
    logic         timeout_err;
    logic [2:0]   err_stage;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_STAGES (N),
        .SYNC_STAGES(SS),
        .MIN_HOLD   (MH),
        .STAGE_DELAY(SD),
        .ACK_TIMEOUT(AT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw_rst_req (sw_rst_req),
        .stage_ack  (stage_ack),
        .rst_n_out  (rst_n_out),
        .seq_done   (seq_done),
        .busy       (busy),
        .timeout_err(timeout_err),
        .err_stage  (err_stage)
    );

    int total = 0;
    int bad   = 0;
    int cyc;
    int t0;
    int rel[N];
    int lat[N];
    int done_e, fault_e, fault_idx;
    int sw_e, shut_m, dwell;
    int seqs = 0;
    int cur_mode;
    int mode_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] obs_vec();
        return 32'({rst_n_out, seq_done, busy, timeout_err, err_stage});
    endfunction

    // Release/ack/fault edges of one sequence, counted from the edge HOLD starts at.
    function automatic void new_plan(input int start);
        int t;
        cur_mode = (mode_q.size() > 0) ? mode_q.pop_front() : 1;
        for (int j = 0; j < N; j++) begin
            lat[j] = (cur_mode == 0) ? 0 : int'($urandom_range(0, 50));
            rel[j] = -1;
        end
        if (cur_mode == 2) lat[2] = NEVER;
        if (cur_mode == 3) begin
            lat[1] = AT - 1;
            lat[2] = AT;
        end
        if (cur_mode == 4) lat[1] = 40;
        if (cur_mode == 6) lat[0] = NEVER;
        t0        = start;
        done_e    = -1;
        fault_e   = -1;
        fault_idx = 0;
        t         = t0 + MH + SD;
        for (int j = 0; j < N; j++) begin
            rel[j] = t;
            if (lat[j] < AT) begin
                t = t + 1 + lat[j];
                if (j == N - 1) done_e = t;
                else t = t + SD;
            end else begin
                fault_e   = t + AT;
                fault_idx = j;
                break;
            end
        end
        sw_e  = -1;
        dwell = int'($urandom_range(1, 8));
        seqs++;
    endfunction

    function automatic int released(input int n);
        int c = 0;
        for (int j = 0; j < N; j++) if (rel[j] >= 0 && n >= rel[j]) c++;
        return c;
    endfunction

    function automatic bit in_idle(input int n);
        return (sw_e < 0) && ((done_e >= 0 && n >= done_e) || (fault_e >= 0 && n >= fault_e));
    endfunction

    function automatic logic [31:0] exp_vec(input int n);
        logic [N-1:0] r;
        logic         d, b, te;
        logic [2:0]   es;
        int           left;
        r = '0; d = 1'b0; b = 1'b1; te = 1'b0; es = '0;
        if (sw_e >= 0 && n >= sw_e) begin
            left = shut_m - (n - sw_e);
            for (int j = 0; j < N; j++) if (j < left) r[j] = 1'b1;
        end else begin
            for (int j = 0; j < N; j++) if (rel[j] >= 0 && n >= rel[j]) r[j] = 1'b1;
            d  = (done_e >= 0 && n >= done_e);
            te = (fault_e >= 0 && n >= fault_e);
            if (te) es = 3'(fault_idx);
            b = !(d || te);
        end
        return 32'({r, d, b, te, es});
    endfunction

    task automatic drive();
        logic [N-1:0] a;
        for (int j = 0; j < N; j++) begin
            if (sw_e < 0 && rel[j] >= 0 && cyc >= rel[j]) a[j] = (cyc >= rel[j] + lat[j]);
            else a[j] = 1'($urandom_range(0, 1));
        end
        stage_ack = a;
        if (in_idle(cyc)) begin
            if (dwell == 0) begin
                sw_rst_req = 1'b1;
                sw_e       = cyc + 1;
                shut_m     = released(cyc);
            end else begin
                sw_rst_req = 1'b0;
                dwell--;
            end
        end else begin
            sw_rst_req = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("seq", obs_vec(), exp_vec(cyc));
        if (sw_e >= 0 && cyc == sw_e + shut_m) new_plan(cyc);
        drive();
    endtask

    // Called just after a negedge; the glitch variant releases before the next posedge.
    task automatic do_reset(input bit glitch);
        #2 reset_n = 1'b0;
        #1 chk("async_clr", obs_vec(), RST_VEC);
        if (glitch) begin
            #1 reset_n = 1'b1;
        end else begin
            @(negedge clk);
            chk("rst_hold", obs_vec(), RST_VEC);
            @(negedge clk);
            reset_n = 1'b1;
        end
        cyc = 0;
        new_plan(SS);
        drive();
    endtask

    initial begin
        int reached;
        reset_n    = 1'b0;
        sw_rst_req = 1'b0;
        stage_ack  = '0;
        cyc        = 0;
        mode_q     = '{0, 4, 4, 3, 2, 6, 1};
        repeat (3) @(negedge clk);
        chk("por", obs_vec(), RST_VEC);
        reset_n = 1'b1;
        new_plan(SS);
        drive();

        // Abort the first lat[1]=40 sequence while it waits on stage 1.
        reached = 0;
        for (int k = 0; k < 1500 && reached == 0; k++) begin
            step();
            if (seqs == 2 && sw_e < 0 && rel[1] >= 0 && cyc == rel[1] + 10) reached = 1;
        end
        chk("reach_wait1", 32'(reached), 32'd1);
        do_reset(1'b0);

        for (int k = 0; k < 2500; k++) step();
        chk("modes_used", 32'(seqs >= 8), 32'd1);

        do_reset(1'b1);
        for (int k = 0; k < 400; k++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
